// File: rtl/tl45_pkg.sv
// Shared types and constants for the tl45 pipeline control blocks.
package tl45_pkg;

    // Hazard sequencer states; encoding is visible on o_state.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LD_STALL = 2'd1,
        HZ_FLUSH    = 2'd2,
        HZ_TRAP     = 2'd3
    } hz_state_t;

    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam logic [3:0] REG_SP   = 4'hF;

    // Load opcodes; execute decodes these into i_ex_is_load.
    localparam logic [4:0] OP_LW    = 5'h14;
    localparam logic [4:0] OP_LB    = 5'h15;
    localparam logic [4:0] OP_LBSE  = 5'h16;
    localparam logic [4:0] OP_LHW   = 5'h17;
    localparam logic [4:0] OP_LHWSE = 5'h18;

    function automatic logic is_load_op(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBSE) ||
               (op == OP_LHW) || (op == OP_LHWSE);
    endfunction

endpackage

// File: rtl/tl45_seq_counter.sv
// Load/decrement/hold sequence counter shared by the FLUSH and LD_STALL states.
// o_done flags the last cycle of a sequence (count == 1).
module tl45_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load beats decrement; neither means hold.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign o_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tl45_hazard_ctrl.sv
// Stall/flush sequencer for the tl45 fetch/decode/execute pipeline.
// Handshake: stall holds a stage's register; flush clears the decode buffer and wins
// over stall; bubble makes execute take a NOP instead of the decode buffer.
// Optional feature macro: TL45_HAZARD_PERF_EN adds stall-cycle and flush counters.
module tl45_hazard_ctrl
    import tl45_pkg::*;
#(
    parameter int FLUSH_CYCLES    = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_dec_valid,
    input  logic [3:0]  i_dec_sr1,
    input  logic [3:0]  i_dec_sr2,
    input  logic        i_dec_err,
    input  logic [31:0] i_dec_pc,
    input  logic        i_ex_is_load,
    input  logic [3:0]  i_ex_dr,
    input  logic        i_mem_busy,
    input  logic        i_br_taken,
    input  logic        i_err_ack,
    output logic        o_fetch_stall,
    output logic        o_dec_stall,
    output logic        o_dec_flush,
    output logic        o_ex_bubble,
    output logic        o_ex_stall,
    output logic        o_trap,
    output logic [31:0] o_trap_pc,
    output logic [1:0]  o_state
`ifdef TL45_HAZARD_PERF_EN
    ,
    output logic [31:0] o_perf_stall_cyc,
    output logic [15:0] o_perf_flush_cnt
`endif
);

    hz_state_t        state_q, state_d;
    logic             trap_q, trap_d;
    logic [31:0]      trap_pc_q, trap_pc_d;
    logic             cnt_load, cnt_dec, cnt_done;
    logic [CNT_W-1:0] cnt_load_val;
    logic             hazard;
    logic             br_accept;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = i_dec_valid && i_ex_is_load && (i_ex_dr != REG_ZERO) &&
                    ((i_ex_dr == i_dec_sr1) || (i_ex_dr == i_dec_sr2));

    // Next state and Mealy stall/flush/bubble outputs.
    always_comb begin
        state_d       = state_q;
        trap_d        = trap_q;
        trap_pc_d     = trap_pc_q;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
        br_accept     = 1'b0;
        o_fetch_stall = 1'b0;
        o_dec_stall   = 1'b0;
        o_dec_flush   = 1'b0;
        o_ex_bubble   = 1'b0;
        o_ex_stall    = 1'b0;
        if (!i_reset_n) begin
            // Outputs held quiet while reset is asserted.
            state_d = HZ_RUN;
        end else if (state_q == HZ_TRAP) begin
            o_fetch_stall = 1'b1;
            o_dec_stall   = 1'b1;
            o_ex_bubble   = 1'b1;
            if (i_err_ack) begin
                o_dec_flush = 1'b1;
                trap_d      = 1'b0;
                state_d     = HZ_RUN;
            end
        end else if (i_mem_busy) begin
            // Whole pipe freezes; sequence counter holds its place.
            o_fetch_stall = 1'b1;
            o_dec_stall   = 1'b1;
            o_ex_stall    = 1'b1;
        end else if (i_br_taken) begin
            br_accept   = 1'b1;
            o_dec_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(FLUSH_CYCLES - 1);
                state_d      = HZ_FLUSH;
            end else begin
                state_d = HZ_RUN;
            end
        end else begin
            case (state_q)
                HZ_FLUSH: begin
                    // Wrong-path instructions: hazards and decode errors ignored.
                    o_dec_flush = 1'b1;
                    cnt_dec     = 1'b1;
                    if (cnt_done) state_d = HZ_RUN;
                end
                HZ_LD_STALL: begin
                    o_fetch_stall = 1'b1;
                    o_dec_stall   = 1'b1;
                    o_ex_bubble   = 1'b1;
                    cnt_dec       = 1'b1;
                    if (cnt_done) state_d = HZ_RUN;
                end
                default: begin
                    if (i_dec_err && i_dec_valid) begin
                        o_dec_flush   = 1'b1;
                        o_fetch_stall = 1'b1;
                        trap_d        = 1'b1;
                        trap_pc_d     = i_dec_pc;
                        state_d       = HZ_TRAP;
                    end else if (hazard) begin
                        o_fetch_stall = 1'b1;
                        o_dec_stall   = 1'b1;
                        o_ex_bubble   = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(LOAD_USE_CYCLES - 1);
                            state_d      = HZ_LD_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // State and trap registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= HZ_RUN;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    tl45_seq_counter #(.CNT_W(CNT_W)) u_seq_cnt (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_dec      (cnt_dec),
        .o_done     (cnt_done)
    );

    assign o_trap    = trap_q;
    assign o_trap_pc = trap_pc_q;
    assign o_state   = state_q;

`ifdef TL45_HAZARD_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating performance counters.
    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_cnt_d = flush_cnt_q;
        if (o_dec_stall && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 1'b1;
        if (br_accept && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Performance counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_perf_stall_cyc = stall_cyc_q;
    assign o_perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_tl45_hazard_ctrl.sv
// Directed bench for tl45_hazard_ctrl: instance a uses LOAD_USE_CYCLES=1,
// instance b uses LOAD_USE_CYCLES=3; both use FLUSH_CYCLES=2.
module tb_tl45_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        dec_valid, dec_err, ex_is_load, mem_busy, br_taken, err_ack;
    logic [3:0]  dec_sr1, dec_sr2, ex_dr;
    logic [31:0] dec_pc;

    logic        a_fs, a_ds, a_df, a_eb, a_es, a_trap;
    logic [31:0] a_trap_pc;
    logic [1:0]  a_state;
    logic        b_fs, b_ds, b_df, b_eb, b_es, b_trap;
    logic [31:0] b_trap_pc;
    logic [1:0]  b_state;
`ifdef TL45_HAZARD_PERF_EN
    logic [31:0] a_psc, b_psc;
    logic [15:0] a_pfc, b_pfc;
`endif

    int errors = 0;
    int checks = 0;

    // {fetch_stall, dec_stall, dec_flush, ex_bubble, ex_stall}
    localparam logic [4:0] O_NONE   = 5'b00000;
    localparam logic [4:0] O_BUBBLE = 5'b11010;
    localparam logic [4:0] O_FLUSH  = 5'b00100;
    localparam logic [4:0] O_BUSY   = 5'b11001;
    localparam logic [4:0] O_TENTRY = 5'b10100;
    localparam logic [4:0] O_TEXIT  = 5'b11110;

    wire [4:0] a_outs = {a_fs, a_ds, a_df, a_eb, a_es};
    wire [4:0] b_outs = {b_fs, b_ds, b_df, b_eb, b_es};

    tl45_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_CYCLES(1), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_reset_n(rst_a_n), .i_dec_valid(dec_valid), .i_dec_sr1(dec_sr1),
        .i_dec_sr2(dec_sr2), .i_dec_err(dec_err), .i_dec_pc(dec_pc), .i_ex_is_load(ex_is_load),
        .i_ex_dr(ex_dr), .i_mem_busy(mem_busy), .i_br_taken(br_taken), .i_err_ack(err_ack),
        .o_fetch_stall(a_fs), .o_dec_stall(a_ds), .o_dec_flush(a_df), .o_ex_bubble(a_eb),
        .o_ex_stall(a_es), .o_trap(a_trap), .o_trap_pc(a_trap_pc), .o_state(a_state)
`ifdef TL45_HAZARD_PERF_EN
        , .o_perf_stall_cyc(a_psc), .o_perf_flush_cnt(a_pfc)
`endif
    );

    tl45_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_CYCLES(3), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_reset_n(rst_b_n), .i_dec_valid(dec_valid), .i_dec_sr1(dec_sr1),
        .i_dec_sr2(dec_sr2), .i_dec_err(dec_err), .i_dec_pc(dec_pc), .i_ex_is_load(ex_is_load),
        .i_ex_dr(ex_dr), .i_mem_busy(mem_busy), .i_br_taken(br_taken), .i_err_ack(err_ack),
        .o_fetch_stall(b_fs), .o_dec_stall(b_ds), .o_dec_flush(b_df), .o_ex_bubble(b_eb),
        .o_ex_stall(b_es), .o_trap(b_trap), .o_trap_pc(b_trap_pc), .o_state(b_state)
`ifdef TL45_HAZARD_PERF_EN
        , .o_perf_stall_cyc(b_psc), .o_perf_flush_cnt(b_pfc)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_err = 1'b0; ex_is_load = 1'b0; mem_busy = 1'b0;
        br_taken = 1'b0; err_ack = 1'b0;
        dec_sr1 = 4'd0; dec_sr2 = 4'd0; ex_dr = 4'd0; dec_pc = 32'd0;
    endtask

    task automatic set_load_use(input logic [3:0] dr, input logic [3:0] s1, input logic [3:0] s2);
        dec_valid = 1'b1; ex_is_load = 1'b1; ex_dr = dr; dec_sr1 = s1; dec_sr2 = s2;
    endtask

    initial begin
        idle_inputs();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_outs", 32'(a_outs), 32'(O_NONE));
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_trap", 32'(a_trap), 32'd0);
        check("rst_trap_pc", a_trap_pc, 32'd0);
        rst_a_n = 1'b1;
        tick();

        // 1: load-use on sr1, single bubble cycle
        set_load_use(4'd3, 4'd3, 4'd9);
        #1 check("lu_sr1_outs", 32'(a_outs), 32'(O_BUBBLE));
        tick();
        check("lu_sr1_state", 32'(a_state), 32'd0);
        ex_is_load = 1'b0;
        #1 check("lu_sr1_after", 32'(a_outs), 32'(O_NONE));
        tick();

        // 2: r0 exempt, non-load exempt, sr2 match, invalid decode
        set_load_use(4'd0, 4'd7, 4'd0);
        #1 check("lu_r0", 32'(a_outs), 32'(O_NONE));
        set_load_use(4'd5, 4'd5, 4'd1);
        ex_is_load = 1'b0;
        #1 check("lu_not_load", 32'(a_outs), 32'(O_NONE));
        set_load_use(4'd4, 4'd2, 4'd4);
        #1 check("lu_sr2", 32'(a_outs), 32'(O_BUBBLE));
        dec_valid = 1'b0;
        #1 check("lu_invalid", 32'(a_outs), 32'(O_NONE));
        idle_inputs();
        tick();

        // 3: branch flush of two cycles, then re-branch inside FLUSH
        br_taken = 1'b1;
        #1 check("br_c1", 32'(a_outs), 32'(O_FLUSH));
        tick();
        check("br_state_flush", 32'(a_state), 32'd2);
        br_taken = 1'b0;
        #1 check("br_c2", 32'(a_outs), 32'(O_FLUSH));
        tick();
        check("br_state_run", 32'(a_state), 32'd0);
        #1 check("br_done", 32'(a_outs), 32'(O_NONE));
        br_taken = 1'b1;
        #1 check("rebr_c1", 32'(a_outs), 32'(O_FLUSH));
        tick();
        #1 check("rebr_c2", 32'(a_outs), 32'(O_FLUSH));
        tick();
        check("rebr_state", 32'(a_state), 32'd2);
        br_taken = 1'b0;
        set_load_use(4'd6, 4'd6, 4'd6);
        dec_err = 1'b1;
        #1 check("rebr_c3_ignore", 32'(a_outs), 32'(O_FLUSH));
        tick();
        idle_inputs();
        check("rebr_state_run", 32'(a_state), 32'd0);
        #1 check("rebr_done", 32'(a_outs), 32'(O_NONE));

        // 4: decode error trap, hold 10 cycles, acknowledge
        dec_valid = 1'b1; dec_err = 1'b1; dec_pc = 32'h100;
        #1 check("trap_entry", 32'(a_outs), 32'(O_TENTRY));
        tick();
        idle_inputs();
        dec_pc = 32'h200;
        check("trap_state", 32'(a_state), 32'd3);
        check("trap_flag", 32'(a_trap), 32'd1);
        check("trap_pc", a_trap_pc, 32'h100);
        for (int i = 0; i < 10; i++) begin
            br_taken = (i == 3);
            mem_busy = (i == 5);
            #1 check($sformatf("trap_hold%0d", i), 32'(a_outs), 32'(O_BUBBLE));
            tick();
            check($sformatf("trap_hold_st%0d", i), 32'(a_state), 32'd3);
        end
        idle_inputs();
        err_ack = 1'b1;
        #1 check("trap_exit", 32'(a_outs), 32'(O_TEXIT));
        tick();
        err_ack = 1'b0;
        check("trap_exit_state", 32'(a_state), 32'd0);
        check("trap_exit_flag", 32'(a_trap), 32'd0);
        check("trap_pc_held", a_trap_pc, 32'h100);
        #1 check("trap_after", 32'(a_outs), 32'(O_NONE));

        // 5: mem_busy freezes FLUSH with cnt=1
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1;
            #1 check($sformatf("busy_outs%0d", i), 32'(a_outs), 32'(O_BUSY));
            tick();
            check($sformatf("busy_state%0d", i), 32'(a_state), 32'd2);
        end
        mem_busy = 1'b0;
        #1 check("busy_release", 32'(a_outs), 32'(O_FLUSH));
        tick();
        check("busy_rel_state", 32'(a_state), 32'd0);
        mem_busy = 1'b1; br_taken = 1'b1;
        #1 check("busy_over_br", 32'(a_outs), 32'(O_BUSY));
        tick();
        check("busy_over_br_st", 32'(a_state), 32'd0);
        idle_inputs();

        // 6: three-cycle load-use on b, then reset in the middle of LD_STALL
        rst_b_n = 1'b1;
        tick();
        set_load_use(4'd8, 4'd8, 4'd1);
        #1 check("b_lu_c1", 32'(b_outs), 32'(O_BUBBLE));
        tick();
        check("b_lu_st1", 32'(b_state), 32'd1);
        ex_is_load = 1'b0;
        #1 check("b_lu_c2", 32'(b_outs), 32'(O_BUBBLE));
        tick();
        check("b_lu_st2", 32'(b_state), 32'd1);
        #1 check("b_lu_c3", 32'(b_outs), 32'(O_BUBBLE));
        tick();
        check("b_lu_st3", 32'(b_state), 32'd0);
        #1 check("b_lu_done", 32'(b_outs), 32'(O_NONE));
        set_load_use(4'd8, 4'd8, 4'd1);
        tick();
        check("b_rst_pre", 32'(b_state), 32'd1);
        #2 rst_b_n = 1'b0;
        #1 check("b_rst_outs", 32'(b_outs), 32'(O_NONE));
        check("b_rst_state", 32'(b_state), 32'd0);
        tick();
        idle_inputs();
        rst_b_n = 1'b1;
        #1 check("b_rel_outs", 32'(b_outs), 32'(O_NONE));
        tick();
        check("b_rel_state", 32'(b_state), 32'd0);
        #1 check("b_rel_quiet", 32'(b_outs), 32'(O_NONE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
